wb_stage: RTL
=============

Name: wb_stage

Overview:
- Writeback stage directly downstream of the MEM/WB pipeline register; consumes its registered outputs.
- Selects the writeback value: load-extracted memory data, ALU result, or PC+4 for jal.
- Owns the 32x32 register file: 2 asynchronous read ports with write-bypass feed ID.
- Executes syscall (display latch or halt) and keeps retirement statistics.

Parameters:
DISP_CODE, 34, $v0 value that makes a syscall latch $a0 to the display; any other $v0 value halts.
CNT_W, 32, width of the statistic counters (saturating).

Ports:
clk  in  1  clock
clr_n  in  1  asynchronous active-low reset
Enable_in  in  1  valid instruction in WB this cycle
Regwrite_in  in  1  register write request
Memtoreg_in  in  1  1: write load data, 0: write ALU_Result1
Jal_in  in  1  write PC_plus_4_in (overrides Memtoreg_in)
Syscall_in  in  1  syscall instruction
Jmp_in, Jr_in  in  1 each  unconditional jump class
Branch_taken_in  in  1  conditional branch retired taken
Mode_in  in  2  load size: 0 word, 1 half, 2 byte
Signext2_in  in  1  sign-extend sub-word loads
ALU_Result1_in  in  32  ALU result / memory address
RD_in  in  32  raw word read from data memory
PC_plus_4_in  in  32  link value
Write_Reg_in  in  5  destination register
R1_num, R2_num  in  5 each  ID read addresses
R1_data, R2_data  out  32 each  ID read data
Display  out  32  last displayed $a0
Halt  out  1  sticky halt flag
Cycles, Retired, Jumps, Branches_taken  out  CNT_W each  statistics

Behaviour:
- Async reset (clr_n=0): all 32 registers, Display, Halt, all counters cleared to 0 immediately; reset mid-operation discards any pending write.
- wr_en = Enable_in & Regwrite_in & !Halt & (Write_Reg_in != 0). Register 0 reads 0 and is never written.
- Load extract uses ALU_Result1_in[1:0], little-endian: byte lane = addr[1:0]; half lane = addr[1] (addr[0] ignored); zero- or sign-extend per Signext2_in; Mode 3 treated as word.
- wdata = Jal_in ? PC_plus_4_in : Memtoreg_in ? load_data : ALU_Result1_in.
- Write on posedge clk; read ports combinational with bypass: if wr_en and R*_num == Write_Reg_in (nonzero), R*_data = wdata in the same cycle.
- Syscall when Enable_in & Syscall_in & !Halt: reg[2] == DISP_CODE -> Display <= reg[4] (bypass N/A, single writer); else Halt <= 1 at that edge. Halt is sticky until reset.
- Machine state machine: RUN -> HALTED on halting syscall; HALTED -> RUN only by reset. In HALTED: no register writes, no Display updates, all counters frozen.
- Counters (RUN only), saturate at all-ones: Cycles +1 every clock; Retired +1 when Enable_in; Jumps +1 when Enable_in & (Jmp_in|Jr_in|Jal_in); Branches_taken +1 when Enable_in & Branch_taken_in.
- The halting syscall itself counts as retired; its cycle is counted.

Optional Feature:
WB_STATS_EN: defined -> counters as above. Undefined -> counter registers not built, Cycles/Retired/Jumps/Branches_taken tied to 0; all other behaviour unchanged.

Decomposition:
- Package mips_wb_pkg: REG_ZERO=0, REG_V0=2, REG_A0=4, REG_RA=31; MODE_WORD/MODE_HALF/MODE_BYTE constants; load_extract function.
- Sub-module reg_file_2r1w: 32x32 storage, async clear, write port, two bypassed read ports.

Test Plan:
- Reset: clr_n low mid-write of reg 5 = 0x1234 -> reg 5 reads 0, Halt=0, Display=0, counters 0.
- Write/bypass: Regwrite to reg 8, ALU_Result1=0xDEADBEEF, R1_num=8 same cycle -> R1_data=0xDEADBEEF combinationally; Write_Reg=0 -> R1_data for reg 0 stays 0.
- Loads: RD=0x80FF7F01, addr[1:0]=1, byte, signed -> 0x0000007F; addr=3 signed -> 0xFFFFFF80; half, addr=2, unsigned -> 0x000080FF.
- Jal: Jal_in=1, PC_plus_4=0x00000040, Write_Reg=31 -> reg 31 = 0x40, Jumps +1.
- Syscall: reg2=34, reg4=0x55 -> Display=0x55, Halt=0; then reg2=10 -> Halt=1; subsequent writes ignored, Cycles frozen.
- Saturation (WB_STATS_EN, CNT_W=4): 20 valid cycles -> Cycles=Retired=15; macro undefined -> all counters 0.

Source files
------------

// File: rtl/mips_wb_pkg.sv
// Shared constants, machine state encoding and the load-extract helper for the writeback stage.
package mips_wb_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_V0   = 5'd2;
  localparam logic [4:0] REG_A0   = 5'd4;
  localparam logic [4:0] REG_RA   = 5'd31;

  localparam logic [1:0] MODE_WORD = 2'd0;
  localparam logic [1:0] MODE_HALF = 2'd1;
  localparam logic [1:0] MODE_BYTE = 2'd2;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } machine_state_e;

  // Little-endian lane select; mode 3 falls through to a full word.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  addr,
                                               input logic [1:0]  mode,
                                               input logic        sign_ext);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half_v = addr[1] ? word[31:16] : word[15:0];
    case (addr)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    case (mode)
      MODE_HALF: res = {{16{sign_ext & half_v[15]}}, half_v};
      MODE_BYTE: res = {{24{sign_ext & byte_v[7]}}, byte_v};
      default:   res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// 32x32 register file: one write port, two bypassed async read ports, plus raw $v0/$a0 taps.
module reg_file_2r1w
  import mips_wb_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  r1_num,
  input  logic [4:0]  r2_num,
  output logic [31:0] r1_data,
  output logic [31:0] r2_data,
  output logic [31:0] v0_data,
  output logic [31:0] a0_data
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != REG_ZERO) begin
      regs[waddr] <= wdata;
    end
  end

  // Same-cycle forwarding so ID sees the value being retired right now.
  always_comb begin
    r1_data = regs[r1_num];
    r2_data = regs[r2_num];
    if (we && waddr != REG_ZERO && r1_num == waddr) r1_data = wdata;
    if (we && waddr != REG_ZERO && r2_num == waddr) r2_data = wdata;
    if (r1_num == REG_ZERO) r1_data = '0;
    if (r2_num == REG_ZERO) r2_data = '0;
  end

  assign v0_data = regs[REG_V0];
  assign a0_data = regs[REG_A0];

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select, register file, syscall display/halt and retirement counters.
// Counters are only built when WB_STATS_EN is defined; otherwise they read as zero.
module wb_stage
  import mips_wb_pkg::*;
#(
  parameter int unsigned DISP_CODE = 34,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             Enable_in,
  input  logic             Regwrite_in,
  input  logic             Memtoreg_in,
  input  logic             Jal_in,
  input  logic             Syscall_in,
  input  logic             Jmp_in,
  input  logic             Jr_in,
  input  logic             Branch_taken_in,
  input  logic [1:0]       Mode_in,
  input  logic             Signext2_in,
  input  logic [31:0]      ALU_Result1_in,
  input  logic [31:0]      RD_in,
  input  logic [31:0]      PC_plus_4_in,
  input  logic [4:0]       Write_Reg_in,
  input  logic [4:0]       R1_num,
  input  logic [4:0]       R2_num,
  output logic [31:0]      R1_data,
  output logic [31:0]      R2_data,
  output logic [31:0]      Display,
  output logic             Halt,
  output logic [CNT_W-1:0] Cycles,
  output logic [CNT_W-1:0] Retired,
  output logic [CNT_W-1:0] Jumps,
  output logic [CNT_W-1:0] Branches_taken
);

  machine_state_e state_q, state_d;
  logic        halted, wr_en, syscall_fire, disp_hit;
  logic [31:0] load_data, wdata, v0_data, a0_data, display_q;

  assign halted       = (state_q == ST_HALTED);
  assign wr_en        = Enable_in & Regwrite_in & ~halted & (Write_Reg_in != REG_ZERO);
  assign syscall_fire = Enable_in & Syscall_in & ~halted;
  assign disp_hit     = (v0_data == 32'(DISP_CODE));

  assign load_data = load_extract(RD_in, ALU_Result1_in[1:0], Mode_in, Signext2_in);
  assign wdata     = Jal_in ? PC_plus_4_in : (Memtoreg_in ? load_data : ALU_Result1_in);

  reg_file_2r1w u_rf (
    .clk     (clk),
    .clr_n   (clr_n),
    .we      (wr_en),
    .waddr   (Write_Reg_in),
    .wdata   (wdata),
    .r1_num  (R1_num),
    .r2_num  (R2_num),
    .r1_data (R1_data),
    .r2_data (R2_data),
    .v0_data (v0_data),
    .a0_data (a0_data)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= ST_RUN;
      display_q <= '0;
    end else begin
      state_q <= state_d;
      if (syscall_fire && disp_hit) display_q <= a0_data;
    end
  end

  // Only reset leaves HALTED.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && syscall_fire && !disp_hit) state_d = ST_HALTED;
  end

  assign Display = display_q;
  assign Halt    = halted;

`ifdef WB_STATS_EN
  logic [CNT_W-1:0] cycles_q, retired_q, jumps_q, branches_q;

  // Saturating counters; the halting syscall's own edge still counts since state is RUN then.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cycles_q   <= '0;
      retired_q  <= '0;
      jumps_q    <= '0;
      branches_q <= '0;
    end else if (!halted) begin
      if (!(&cycles_q)) cycles_q <= cycles_q + 1'b1;
      if (Enable_in && !(&retired_q)) retired_q <= retired_q + 1'b1;
      if (Enable_in && (Jmp_in || Jr_in || Jal_in) && !(&jumps_q)) jumps_q <= jumps_q + 1'b1;
      if (Enable_in && Branch_taken_in && !(&branches_q)) branches_q <= branches_q + 1'b1;
    end
  end

  assign Cycles         = cycles_q;
  assign Retired        = retired_q;
  assign Jumps          = jumps_q;
  assign Branches_taken = branches_q;
`else
  logic unused_stats;
  assign unused_stats   = ^{Jmp_in, Jr_in, Branch_taken_in};
  assign Cycles         = '0;
  assign Retired        = '0;
  assign Jumps          = '0;
  assign Branches_taken = '0;
`endif

endmodule
